// File: rtl/onecold_rr_encoder.sv
// Active-low N-bit request vector -> binary code (fixed priority or round-robin), registered behind a valid/ready stage.
// Optional macro ONECOLD_ERR_CNT_EN adds err_cnt, a saturating count of multi-hot/none-active accepts.
module onecold_rr_encoder #(
  parameter int N    = 4,
  parameter int MODE = 0,
  parameter int W    = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_code,
  output logic         out_multi,
  output logic         out_none
`ifdef ONECOLD_ERR_CNT_EN
  , output logic [7:0] err_cnt
`endif
);

  logic [N-1:0] w_act;
  logic         w_multi;
  logic         w_none;
  logic         w_accept;
  logic [W-1:0] w_fp_sel;
  logic [W-1:0] w_rr_sel;
  logic         w_rr_found;
  logic [W-1:0] w_sel;

  logic         r_valid;
  logic [W-1:0] r_code;
  logic         r_multi;
  logic         r_none;
  logic [W-1:0] r_last;

  assign w_act    = ~in_vec;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign w_multi  = |(w_act & (w_act - N'(1)));
  assign w_none   = ~|w_act;
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    int idx;
    w_fp_sel   = '0;
    w_rr_sel   = '0;
    w_rr_found = 1'b0;
    idx        = 0;
    // Code c lives at bit N-1-c; scanning down leaves the lowest active code.
    for (int c = N - 1; c >= 0; c--) begin
      if (w_act[N-1-c]) w_fp_sel = W'(c);
    end
    for (int k = 0; k < N; k++) begin
      idx = int'(r_last) + 1 + k;
      if (idx >= N) idx = idx - N;
      if (!w_rr_found && w_act[N-1-idx]) begin
        w_rr_sel   = W'(idx);
        w_rr_found = 1'b1;
      end
    end
  end

  assign w_sel = (MODE == 1) ? w_rr_sel : w_fp_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_code  <= '0;
      r_multi <= 1'b0;
      r_none  <= 1'b0;
      r_last  <= W'(N - 1);
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_code  <= w_none ? '0 : w_sel;
      r_multi <= w_multi;
      r_none  <= w_none;
      if (MODE == 1 && !w_none) r_last <= w_rr_sel;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_code  = r_code;
  assign out_multi = r_multi;
  assign out_none  = r_none;

`ifdef ONECOLD_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'd0;
    end else if (w_accept && (w_multi || w_none) && r_err_cnt != 8'hFF) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_onecold_rr_encoder.sv
// Bench for onecold_rr_encoder: a fixed-priority and a round-robin instance share stimulus and face one reference model.
module tb_onecold_rr_encoder;
  localparam int N = 4;
  localparam int W = $clog2(N);

  logic clk = 1'b0;
  logic rst_n;
  logic t_vld, t_rdy;
  logic [N-1:0] t_vec;

  logic ir0, v0, m0, n0, ir1, v1, m1, n1;
  logic [W-1:0] c0, c1;
`ifdef ONECOLD_ERR_CNT_EN
  logic [7:0] ec0, ec1;
`endif

  int total = 0;
  int bad   = 0;

  logic         e_valid, e_multi, e_none, e_ir;
  logic [W-1:0] e_code0, e_code1;
  int           e_ptr;
  int           e_err;
  logic         ir0_s, ir1_s;
  logic [W+2:0] g0, g1, x0, x1;

  always #5 clk = ~clk;

  onecold_rr_encoder #(.N(N), .MODE(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(t_vld), .in_ready(ir0), .in_vec(t_vec),
    .out_valid(v0), .out_ready(t_rdy), .out_code(c0), .out_multi(m0), .out_none(n0)
`ifdef ONECOLD_ERR_CNT_EN
    , .err_cnt(ec0)
`endif
  );

  onecold_rr_encoder #(.N(N), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(t_vld), .in_ready(ir1), .in_vec(t_vec),
    .out_valid(v1), .out_ready(t_rdy), .out_code(c1), .out_multi(m1), .out_none(n1)
`ifdef ONECOLD_ERR_CNT_EN
    , .err_cnt(ec1)
`endif
  );

  // Code c corresponds to bit N-1-c; a 0 bit is an active request.
  function automatic int ref_fp(input logic [N-1:0] v);
    for (int c = 0; c < N; c++) if (v[N-1-c] == 1'b0) return c;
    return 0;
  endfunction

  function automatic int ref_rr(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (p + k) % N;
      if (v[N-1-c] == 1'b0) return c;
    end
    return 0;
  endfunction

  task automatic model_reset();
    e_valid = 1'b0; e_multi = 1'b0; e_none = 1'b0;
    e_code0 = '0; e_code1 = '0; e_ptr = N - 1; e_err = 0;
  endtask

  // One clock: drive at the falling edge, advance the model at the rising edge, snapshot at the next falling edge.
  task automatic drive(input logic vld, input logic [N-1:0] vec, input logic rdy);
    int ones;
    t_vld = vld; t_vec = vec; t_rdy = rdy;
    #1;
    ir0_s = ir0; ir1_s = ir1;
    e_ir  = !e_valid || rdy;
    @(posedge clk);
    if (vld && e_ir) begin
      ones    = $countones(~vec);
      e_none  = (ones == 0);
      e_multi = (ones >= 2);
      e_code0 = e_none ? '0 : W'(ref_fp(vec));
      e_code1 = e_none ? '0 : W'(ref_rr(vec, e_ptr));
      if (!e_none) e_ptr = int'(e_code1);
      if ((e_multi || e_none) && e_err < 255) e_err = e_err + 1;
      e_valid = 1'b1;
    end else if (rdy) begin
      e_valid = 1'b0;
    end
    @(negedge clk);
    g0 = {v0, e_valid ? {c0, m0, n0} : '0};
    g1 = {v1, e_valid ? {c1, m1, n1} : '0};
    x0 = {e_valid, e_valid ? {e_code0, e_multi, e_none} : '0};
    x1 = {e_valid, e_valid ? {e_code1, e_multi, e_none} : '0};
  endtask

  task automatic do_reset();
    t_vld = 1'b0; t_rdy = 1'b0; t_vec = '1;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    t_vld = 1'b0; t_rdy = 1'b0; t_vec = '1;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({v0, c0, m0, n0, v1, c1, m1, n1} !== '0) begin
      bad++; $display("FAIL reset_state got=%b %b exp all zero", {v0, c0, m0, n0}, {v1, c1, m1, n1});
    end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if ({ir0, ir1} !== 2'b11) begin bad++; $display("FAIL reset_in_ready got=%b exp=11", {ir0, ir1}); end
    @(negedge clk);
    drive(1'b1, 4'b0100, 1'b0);
    total++;
    if (g0 !== x0 || g1 !== x1) begin bad++; $display("FAIL pre_reset_load got=%b/%b exp=%b/%b", g0, g1, x0, x1); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({v0, c0, m0, n0, v1, c1, m1, n1} !== '0) begin
      bad++; $display("FAIL async_reset got=%b %b exp all zero", {v0, c0, m0, n0}, {v1, c1, m1, n1});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if ({ir0, ir1, v0, v1} !== 4'b1100) begin bad++; $display("FAIL post_reset got=%b exp=1100", {ir0, ir1, v0, v1}); end
    @(negedge clk);
  endtask

  task automatic test_fixed();
    do_reset();
    drive(1'b1, 4'b1011, 1'b1);
    total++;
    if (g0 !== x0 || {v0, c0, m0, n0} !== 5'b1_01_00) begin bad++; $display("FAIL fp_1011 got=%b exp=10100", {v0, c0, m0, n0}); end
    drive(1'b1, 4'b0101, 1'b1);
    total++;
    if (g0 !== x0 || {v0, c0, m0, n0} !== 5'b1_00_10) begin bad++; $display("FAIL fp_0101 got=%b exp=10010", {v0, c0, m0, n0}); end
    total++;
    if (g1 !== x1) begin bad++; $display("FAIL rr_0101 got=%b exp=%b", g1, x1); end
    drive(1'b0, 4'b0000, 1'b1);
    total++;
    if ({v0, v1} !== 2'b00) begin bad++; $display("FAIL drain got=%b exp=00", {v0, v1}); end
  endtask

  task automatic test_rr_sequence();
    logic [W-1:0] seq [6];
    seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, (i < 5) ? 4'b0000 : 4'b1110, 1'b1);
      total++;
      if (g1 !== x1 || c1 !== seq[i] || m1 !== (i < 5)) begin
        bad++; $display("FAIL rr_seq%0d got code=%0d multi=%b exp code=%0d multi=%b", i, c1, m1, seq[i], i < 5);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1'b1, 4'b0111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b1101, 1'b0);
      total++;
      if ({ir0_s, ir1_s} !== 2'b00 || c0 !== 2'd0 || c1 !== 2'd0 || g0 !== x0 || g1 !== x1) begin
        bad++; $display("FAIL hold%0d got rdy=%b%b code=%0d/%0d exp rdy=00 code=0/0", i, ir0_s, ir1_s, c0, c1);
      end
    end
    drive(1'b1, 4'b1101, 1'b1);
    total++;
    if ({ir0_s, ir1_s} !== 2'b11 || {v0, c0} !== 3'b1_10 || {v1, c1} !== 3'b1_10) begin
      bad++; $display("FAIL reload got rdy=%b%b code=%0d/%0d exp rdy=11 code=2/2", ir0_s, ir1_s, c0, c1);
    end
  endtask

  task automatic test_none();
    do_reset();
    drive(1'b1, 4'b1011, 1'b1);
    drive(1'b1, 4'b1111, 1'b1);
    total++;
    if ({v1, c1, m1, n1} !== 5'b1_00_01 || {v0, c0, m0, n0} !== 5'b1_00_01) begin
      bad++; $display("FAIL none got=%b/%b exp=10001", {v0, c0, m0, n0}, {v1, c1, m1, n1});
    end
    drive(1'b1, 4'b0000, 1'b1);
    total++;
    if (c1 !== 2'd2 || g1 !== x1) begin bad++; $display("FAIL none_ptr got=%0d exp=2", c1); end
  endtask

  task automatic test_random();
    logic [N-1:0] vec, one;
    do_reset();
    one = 1;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       vec = '1;
        1:       vec = ~(one << $urandom_range(0, N - 1));
        default: vec = N'($urandom);
      endcase
      drive($urandom_range(0, 3) != 0, vec, $urandom_range(0, 9) < 7);
      total++;
      if (ir0_s !== e_ir || ir1_s !== e_ir) begin bad++; $display("FAIL rnd_rdy%0d got=%b%b exp=%b", i, ir0_s, ir1_s, e_ir); end
      total++;
      if (g0 !== x0) begin bad++; $display("FAIL rnd_fp%0d got=%b exp=%b", i, g0, x0); end
      total++;
      if (g1 !== x1) begin bad++; $display("FAIL rnd_rr%0d got=%b exp=%b", i, g1, x1); end
`ifdef ONECOLD_ERR_CNT_EN
      total++;
      if (int'(ec0) != e_err || int'(ec1) != e_err) begin bad++; $display("FAIL rnd_err%0d got=%0d/%0d exp=%0d", i, ec0, ec1, e_err); end
`endif
    end
  endtask

`ifdef ONECOLD_ERR_CNT_EN
  task automatic test_err_cnt();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 4'b0011, 1'b1);
      if (i == 253 || i == 254 || i == 299) begin
        total++;
        if (int'(ec0) != e_err || int'(ec1) != e_err) begin bad++; $display("FAIL err_sat%0d got=%0d/%0d exp=%0d", i, ec0, ec1, e_err); end
      end
    end
    total++;
    if (ec0 !== 8'd255) begin bad++; $display("FAIL err_255 got=%0d exp=255", ec0); end
    drive(1'b1, 4'b1110, 1'b1);
    drive(1'b1, 4'b0111, 1'b1);
    total++;
    if (ec0 !== 8'd255 || ec1 !== 8'd255) begin bad++; $display("FAIL err_hold got=%0d/%0d exp=255", ec0, ec1); end
    rst_n = 1'b0;
    #1;
    total++;
    if (ec0 !== 8'd0 || ec1 !== 8'd0) begin bad++; $display("FAIL err_reset got=%0d/%0d exp=0", ec0, ec1); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'b1101, 1'b1);
    total++;
    if (ec0 !== 8'd0) begin bad++; $display("FAIL err_single got=%0d exp=0", ec0); end
  endtask
`endif

  initial begin
    test_reset();
    test_fixed();
    test_rr_sequence();
    test_backpressure();
    test_none();
    test_random();
`ifdef ONECOLD_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
